// File: rtl/snake_pkg.sv
// Shared types for the snake body engine: direction codes, FSM states and the
// opposite-direction helper used to reject reversing turns.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_UP    = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_READY = 3'd2,
        S_STEP  = 3'd3,
        S_CHECK = 3'd4,
        S_DEAD  = 3'd5
    } state_t;

    // The codes are laid out so that inverting both bits yields the reverse heading.
    function automatic dir_t opposite(input dir_t d);
        return dir_t'(~d);
    endfunction

endpackage

// File: rtl/snake_body_engine_if.sv
// Control/readout bundle between the key/tick logic, the drawer and the snake body engine.
interface snake_body_engine_if #(
    parameter int MAX_LEN = 16,
    parameter int XW      = 8,
    parameter int YW      = 7
);
    localparam int IW = $clog2(MAX_LEN);
    localparam int LW = $clog2(MAX_LEN + 1);

    logic          start;
    logic          tick;
    logic          dir_valid;
    logic [1:0]    dir_req;
    logic          grow;
    logic [IW-1:0] seg_idx;
    logic [XW-1:0] seg_x;
    logic [YW-1:0] seg_y;
    logic          seg_valid;
    logic [XW-1:0] old_tail_x;
    logic [YW-1:0] old_tail_y;
    logic          tail_freed;
    logic [LW-1:0] length;
    logic          busy;
    logic          step_done;
    logic          dead;

    modport master (
        output start, tick, dir_valid, dir_req, grow, seg_idx,
        input  seg_x, seg_y, seg_valid, old_tail_x, old_tail_y, tail_freed,
               length, busy, step_done, dead
    );

    modport slave (
        input  start, tick, dir_valid, dir_req, grow, seg_idx,
        output seg_x, seg_y, seg_valid, old_tail_x, old_tail_y, tail_freed,
               length, busy, step_done, dead
    );

endinterface

// File: rtl/snake_seg_store.sv
// One coordinate of the snake body: a shift register with bulk load, head shift-in
// and two combinational read ports (drawer read and collision scan).
module snake_seg_store #(
    parameter  int W       = 8,
    parameter  int MAX_LEN = 16,
    localparam int IW      = $clog2(MAX_LEN)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load,
    input  logic                       shift,
    input  logic [MAX_LEN-1:0][W-1:0]  load_data,
    input  logic [W-1:0]               head_in,
    input  logic [IW-1:0]              rd_idx,
    input  logic [IW-1:0]              scan_idx,
    output logic [W-1:0]               rd_data,
    output logic [W-1:0]               scan_data,
    output logic [W-1:0]               head
);
    localparam logic [IW:0] LIM = (IW + 1)'(MAX_LEN);

    logic [W-1:0] seg [MAX_LEN];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_LEN; i++) seg[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < MAX_LEN; i++) seg[i] <= load_data[i];
        end else if (shift) begin
            seg[0] <= head_in;
            for (int i = 1; i < MAX_LEN; i++) seg[i] <= seg[i-1];
        end
    end

    // Indices past the array (non power-of-two MAX_LEN) read as zero.
    assign rd_data   = ({1'b0, rd_idx}   < LIM) ? seg[rd_idx]   : '0;
    assign scan_data = ({1'b0, scan_idx} < LIM) ? seg[scan_idx] : '0;
    assign head      = seg[0];

endmodule

// File: rtl/snake_body_engine.sv
// Snake body store and stepper: one cell per tick, queued turns, growth,
// wall death and a serial self-collision scan after every step.
module snake_body_engine
    import snake_pkg::*;
#(
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3,
    parameter int XW       = 8,
    parameter int YW       = 7,
    parameter int XSCREEN  = 160,
    parameter int YSCREEN  = 120,
    parameter int CELL     = 10,
    parameter int X0       = 40,
    parameter int Y0       = 60
) (
    input  logic                  CLOCK_50,
    input  logic                  Resetn,
    snake_body_engine_if.slave    bus
);
    localparam int IW = $clog2(MAX_LEN);
    localparam int LW = $clog2(MAX_LEN + 1);

    localparam logic signed [XW:0] STEP_X = (XW + 1)'(CELL);
    localparam logic signed [YW:0] STEP_Y = (YW + 1)'(CELL);
    localparam logic signed [XW:0] XMAX   = (XW + 1)'(XSCREEN - CELL);
    localparam logic signed [YW:0] YMAX   = (YW + 1)'(YSCREEN - CELL);
    localparam logic [LW-1:0]      MAXL   = LW'(MAX_LEN);
    localparam logic [LW-1:0]      INITL  = LW'(INIT_LEN);

    state_t state_q, state_d;
    dir_t   dir_q, pend_q;
    logic   grow_pend;
    logic [LW-1:0] length_q, scan_k, len_m1;
    logic [XW-1:0] old_tail_x, head_x, scan_x;
    logic [YW-1:0] old_tail_y, head_y, scan_y;
    logic   tail_freed, step_done_q;
    logic   do_load, do_shift, wall, hit, last;
    logic [IW-1:0] scan_idx;
    logic signed [XW:0] hx_s, nx;
    logic signed [YW:0] hy_s, ny;
    logic [MAX_LEN-1:0][XW-1:0] init_x;
    logic [MAX_LEN-1:0][YW-1:0] init_y;

    always_comb begin
        for (int i = 0; i < MAX_LEN; i++) begin
            init_x[i] = (i < INIT_LEN) ? XW'(X0 - i * CELL) : '0;
            init_y[i] = (i < INIT_LEN) ? YW'(Y0) : '0;
        end
    end

    // Next head in one extra signed bit so leaving the screen on the low side is visible.
    always_comb begin
        hx_s = $signed({1'b0, head_x});
        hy_s = $signed({1'b0, head_y});
        nx   = hx_s;
        ny   = hy_s;
        case (pend_q)
            DIR_RIGHT: nx = hx_s + STEP_X;
            DIR_LEFT:  nx = hx_s - STEP_X;
            DIR_DOWN:  ny = hy_s + STEP_Y;
            default:   ny = hy_s - STEP_Y;
        endcase
        wall = nx[XW] || (nx > XMAX) || ny[YW] || (ny > YMAX);
    end

    // During STEP the scan port fetches the outgoing tail; during CHECK it walks the body.
    assign len_m1   = length_q - 1'b1;
    assign scan_idx = (state_q == S_STEP) ? len_m1[IW-1:0] : scan_k[IW-1:0];
    assign hit      = (scan_x == head_x) && (scan_y == head_y) && (scan_k < length_q);
    assign last     = (scan_k >= len_m1);

    snake_seg_store #(.W(XW), .MAX_LEN(MAX_LEN)) u_seg_x (
        .clk(CLOCK_50), .rst_n(Resetn), .load(do_load), .shift(do_shift),
        .load_data(init_x), .head_in(nx[XW-1:0]), .rd_idx(bus.seg_idx),
        .scan_idx(scan_idx), .rd_data(bus.seg_x), .scan_data(scan_x), .head(head_x)
    );

    snake_seg_store #(.W(YW), .MAX_LEN(MAX_LEN)) u_seg_y (
        .clk(CLOCK_50), .rst_n(Resetn), .load(do_load), .shift(do_shift),
        .load_data(init_y), .head_in(ny[YW-1:0]), .rd_idx(bus.seg_idx),
        .scan_idx(scan_idx), .rd_data(bus.seg_y), .scan_data(scan_y), .head(head_y)
    );

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        do_load  = 1'b0;
        do_shift = 1'b0;
        case (state_q)
            S_INIT: begin
                do_load = 1'b1;
                state_d = S_READY;
            end
            S_READY: if (bus.tick) state_d = S_STEP;
            S_STEP: begin
                if (wall) begin
                    state_d = S_DEAD;
                end else begin
                    do_shift = 1'b1;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                if (hit)       state_d = S_DEAD;
                else if (last) state_d = S_READY;
            end
            default: ;
        endcase
        // start overrides everything, including a step in flight.
        if (bus.start) begin
            state_d  = S_INIT;
            do_shift = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            dir_q       <= DIR_RIGHT;
            pend_q      <= DIR_RIGHT;
            grow_pend   <= 1'b0;
            length_q    <= '0;
            scan_k      <= '0;
            old_tail_x  <= '0;
            old_tail_y  <= '0;
            tail_freed  <= 1'b0;
            step_done_q <= 1'b0;
        end else begin
            step_done_q <= 1'b0;
            if (bus.dir_valid && (dir_t'(bus.dir_req) != opposite(dir_q)))
                pend_q <= dir_t'(bus.dir_req);
            case (state_q)
                S_IDLE, S_DEAD: ;
                S_INIT, S_STEP: grow_pend <= bus.grow;
                default:        if (bus.grow) grow_pend <= 1'b1;
            endcase
            case (state_q)
                S_INIT: begin
                    length_q   <= INITL;
                    dir_q      <= DIR_RIGHT;
                    tail_freed <= 1'b0;
                    pend_q     <= (bus.dir_valid && (dir_t'(bus.dir_req) != DIR_LEFT))
                                  ? dir_t'(bus.dir_req) : DIR_RIGHT;
                end
                S_STEP: begin
                    dir_q <= pend_q;
                    if (do_shift) begin
                        old_tail_x <= scan_x;
                        old_tail_y <= scan_y;
                        scan_k     <= LW'(1);
                        if (grow_pend && (length_q < MAXL)) begin
                            length_q   <= length_q + 1'b1;
                            tail_freed <= 1'b0;
                        end else begin
                            tail_freed <= 1'b1;
                        end
                    end
                end
                S_CHECK: begin
                    scan_k <= scan_k + 1'b1;
                    if (!bus.start && !hit && last) step_done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.seg_valid  = (LW'(bus.seg_idx) < length_q);
    assign bus.old_tail_x = old_tail_x;
    assign bus.old_tail_y = old_tail_y;
    assign bus.tail_freed = tail_freed;
    assign bus.length     = length_q;
    assign bus.busy       = (state_q == S_INIT) || (state_q == S_STEP) || (state_q == S_CHECK);
    assign bus.step_done  = step_done_q;
    assign bus.dead       = (state_q == S_DEAD);

endmodule

// File: tb/tb_snake_body_engine.sv
// Directed bench for snake_body_engine (MAX_LEN=6 so the length cap is reachable quickly).
`timescale 1ns/1ps
module tb_snake_body_engine;
    localparam int MAX_LEN = 6;
    localparam int IW      = $clog2(MAX_LEN);

    logic clk = 1'b0;
    logic rstn;
    always #10 clk = ~clk;

    snake_body_engine_if #(.MAX_LEN(MAX_LEN), .XW(8), .YW(7)) bus();

    snake_body_engine #(.MAX_LEN(MAX_LEN)) dut (
        .CLOCK_50(clk),
        .Resetn(rstn),
        .bus(bus.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int lat;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic seg_at(input string tag, input int i, input int ex, input int ey);
        bus.seg_idx = IW'(i);
        #1;
        chk({tag, "_x"}, 32'(bus.seg_x), ex);
        chk({tag, "_y"}, 32'(bus.seg_y), ey);
    endtask

    // Pulses tick and counts edges until step_done or dead (bounded).
    task automatic do_step(output int n);
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        n = 1;
        while (!bus.step_done && !bus.dead && n < 40) begin
            cyc();
            n++;
        end
    endtask

    task automatic send_dir(input logic [1:0] d);
        bus.dir_valid = 1'b1;
        bus.dir_req   = d;
        cyc();
        bus.dir_valid = 1'b0;
    endtask

    task automatic send_grow();
        bus.grow = 1'b1;
        cyc();
        bus.grow = 1'b0;
    endtask

    task automatic send_start();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    initial begin
        rstn          = 1'b0;
        bus.start     = 1'b0;
        bus.tick      = 1'b0;
        bus.dir_valid = 1'b0;
        bus.dir_req   = 2'b00;
        bus.grow      = 1'b0;
        bus.seg_idx   = '0;
        cyc(2);
        chk("rst_len",   32'(bus.length), 0);
        chk("rst_busy",  32'(bus.busy), 0);
        chk("rst_dead",  32'(bus.dead), 0);
        chk("rst_done",  32'(bus.step_done), 0);
        chk("rst_valid", 32'(bus.seg_valid), 0);
        chk("rst_freed", 32'(bus.tail_freed), 0);
        seg_at("rst_seg0", 0, 0, 0);
        rstn = 1'b1;
        cyc();

        // Start: one INIT cycle, then the three-cell snake laid out leftward.
        send_start();
        chk("init_busy", 32'(bus.busy), 1);
        cyc();
        chk("init_len",  32'(bus.length), 3);
        chk("init_busy2", 32'(bus.busy), 0);
        seg_at("init_seg0", 0, 40, 60);
        seg_at("init_seg2", 2, 20, 60);

        // First step, with a tick issued mid-scan that must be dropped.
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        cyc();
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        lat = 3;
        while (!bus.step_done && !bus.dead && lat < 40) begin
            cyc();
            lat++;
        end
        chk("s1_lat",   lat, 4);
        chk("s1_done",  32'(bus.step_done), 1);
        chk("s1_tx",    32'(bus.old_tail_x), 20);
        chk("s1_ty",    32'(bus.old_tail_y), 60);
        chk("s1_freed", 32'(bus.tail_freed), 1);
        seg_at("s1_seg0", 0, 50, 60);
        seg_at("s1_seg1", 1, 40, 60);
        seg_at("s1_seg2", 2, 30, 60);
        bus.seg_idx = IW'(3);
        #1;
        chk("s1_valid3", 32'(bus.seg_valid), 0);
        cyc(3);
        chk("drop_busy", 32'(bus.busy), 0);
        chk("drop_done", 32'(bus.step_done), 0);
        seg_at("drop_seg0", 0, 50, 60);

        // Reversal request ignored; then down followed by up, the later one wins.
        send_dir(2'b11);
        do_step(lat);
        chk("rev_lat", lat, 4);
        seg_at("rev_seg0", 0, 60, 60);
        chk("rev_tx", 32'(bus.old_tail_x), 30);
        send_dir(2'b01);
        send_dir(2'b10);
        do_step(lat);
        seg_at("up_seg0", 0, 60, 50);
        seg_at("up_seg1", 1, 60, 60);

        // Growth to the cap, then one discarded growth.
        send_grow();
        do_step(lat);
        chk("g4_lat",   lat, 5);
        chk("g4_len",   32'(bus.length), 4);
        chk("g4_freed", 32'(bus.tail_freed), 0);
        send_grow();
        do_step(lat);
        chk("g5_len", 32'(bus.length), 5);
        send_grow();
        do_step(lat);
        chk("g6_lat", lat, 7);
        chk("g6_len", 32'(bus.length), 6);
        send_grow();
        do_step(lat);
        chk("gmax_len",   32'(bus.length), 6);
        chk("gmax_freed", 32'(bus.tail_freed), 1);
        seg_at("gmax_seg0", 0, 60, 10);

        // Right wall: eleven steps reach x=150, the next one kills without shifting.
        send_start();
        cyc();
        for (int i = 0; i < 11; i++) begin
            do_step(lat);
            chk("walk_lat", lat, 4);
        end
        seg_at("wall_pre", 0, 150, 60);
        do_step(lat);
        chk("wall_lat",  lat, 2);
        chk("wall_dead", 32'(bus.dead), 1);
        chk("wall_done", 32'(bus.step_done), 0);
        chk("wall_len",  32'(bus.length), 3);
        seg_at("wall_seg0", 0, 150, 60);
        seg_at("wall_seg1", 1, 140, 60);
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        cyc(2);
        chk("dead_busy", 32'(bus.busy), 0);
        chk("dead_hold", 32'(bus.dead), 1);
        seg_at("dead_seg0", 0, 150, 60);

        // Self collision: length 5 folding back onto its own tail.
        send_start();
        cyc();
        chk("re_dead", 32'(bus.dead), 0);
        send_grow();
        do_step(lat);
        send_grow();
        do_step(lat);
        chk("sc_len", 32'(bus.length), 5);
        send_dir(2'b01);
        do_step(lat);
        seg_at("sc_down", 0, 60, 70);
        send_dir(2'b11);
        do_step(lat);
        seg_at("sc_left", 0, 50, 70);
        send_dir(2'b10);
        do_step(lat);
        chk("sc_lat",  lat, 6);
        chk("sc_dead", 32'(bus.dead), 1);
        chk("sc_done", 32'(bus.step_done), 0);
        seg_at("sc_seg4", 4, 50, 60);
        send_start();
        cyc();
        chk("rs_len",  32'(bus.length), 3);
        chk("rs_dead", 32'(bus.dead), 0);
        seg_at("rs_seg0", 0, 40, 60);

        // Reset in the middle of a scan, then a tick in IDLE.
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        cyc();
        chk("mid_busy", 32'(bus.busy), 1);
        rstn = 1'b0;
        cyc();
        chk("mr_len",   32'(bus.length), 0);
        chk("mr_busy",  32'(bus.busy), 0);
        chk("mr_dead",  32'(bus.dead), 0);
        chk("mr_done",  32'(bus.step_done), 0);
        chk("mr_freed", 32'(bus.tail_freed), 0);
        chk("mr_tx",    32'(bus.old_tail_x), 0);
        seg_at("mr_seg0", 0, 0, 0);
        rstn = 1'b1;
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        cyc();
        chk("idle_busy", 32'(bus.busy), 0);
        chk("idle_len",  32'(bus.length), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "bench timeout");
    end

endmodule
